// File: rtl/pdp8l_fifo_tty_if.sv
// Bus bundle for the buffered PDP-8/L teletype: ARM register bus plus CPU IOP bus.
// The master side (ARM/CPU) drives strobes and data; the slave side (device) answers.
interface pdp8l_fifo_tty_if;
  logic        armwrite;
  logic [2:0]  armraddr;
  logic [2:0]  armwaddr;
  logic [31:0] armwdata;
  logic [31:0] armrdata;
  logic        iopstart;
  logic        iopstop;
  logic [11:0] ioopcode;
  logic [11:0] cputodev;
  logic [11:0] devtocpu;
  logic        AC_CLEAR;
  logic        IO_SKIP;
  logic        INT_RQST;

  modport master (
    output armwrite, armraddr, armwaddr, armwdata,
    output iopstart, iopstop, ioopcode, cputodev,
    input  armrdata, devtocpu, AC_CLEAR, IO_SKIP, INT_RQST
  );

  modport slave (
    input  armwrite, armraddr, armwaddr, armwdata,
    input  iopstart, iopstop, ioopcode, cputodev,
    output armrdata, devtocpu, AC_CLEAR, IO_SKIP, INT_RQST
  );
endinterface

// File: rtl/pdp8l_fifo_tty.sv
// Buffered PDP-8/L teletype: keyboard and printer FIFOs between the ARM register bus
// and the CPU IOP bus, with a one-char printer staging register and overflow sticky bits.
module pdp8l_fifo_tty #(
  parameter logic [5:0] KBDEV     = 6'o03,
  parameter int         DEPTHLOG2 = 4
) (
  input logic             CLOCK,
  input logic             RESET,
  pdp8l_fifo_tty_if.slave bus
);
  localparam logic [11:0] KBIO = 12'o6000 | {3'b000, KBDEV, 3'b000};
  localparam logic [11:0] TTIO = KBIO + 12'o0010;

  typedef logic [DEPTHLOG2-1:0] ptr_t;
  typedef logic [DEPTHLOG2:0]   cnt_t;
  localparam ptr_t PTR_ONE = ptr_t'(1);
  localparam cnt_t CNT_ONE = cnt_t'(1);

  logic        enable, intenab, kbovf, provf, prflag, prpend;
  ptr_t        kbwr, kbrd, prwr, prrd;
  cnt_t        kbcount, prcount;
  logic [7:0]  prstage;
  logic [7:0]  kbmem [1 << DEPTHLOG2];
  logic [7:0]  prmem [1 << DEPTHLOG2];
  logic [11:0] dev_q;
  logic        clr_q, skip_q;
  logic [31:0] rdata;

  logic [7:0]  kbhead, prhead;
  logic        kbflag, kbfull, prnotempty, prfull, int_rqst;
  logic        iop_go, kb_iop, tt_iop;
  logic [2:0]  fn;
  logic        arm_w1, kb_flush, kb_push_req, kb_push, kb_pop;
  logic        pr_pop, pr_load, pr_xfer;

  assign kbhead     = kbmem[kbrd];
  assign prhead     = prmem[prrd];
  assign kbflag     = |kbcount;
  assign kbfull     = kbcount[DEPTHLOG2];
  assign prnotempty = |prcount;
  assign prfull     = prcount[DEPTHLOG2];
  assign int_rqst   = intenab & (kbflag | prflag);

  assign iop_go = bus.iopstart & enable;
  assign kb_iop = iop_go & (bus.ioopcode[11:3] == KBIO[11:3]);
  assign tt_iop = iop_go & (bus.ioopcode[11:3] == TTIO[11:3]);
  assign fn     = bus.ioopcode[2:0];

  // Flush beats a same-cycle IOP pop; a pop frees the slot a same-cycle push needs.
  assign arm_w1      = bus.armwrite & (bus.armwaddr == 3'd1);
  assign kb_flush    = arm_w1 & bus.armwdata[28];
  assign kb_push_req = bus.armwrite & (bus.armwaddr == 3'd2);
  assign kb_pop      = kb_iop & ((fn == 3'd2) | (fn == 3'd6)) & kbflag & ~kb_flush;
  assign kb_push     = kb_push_req & (~kbfull | kb_pop);

  assign pr_pop  = bus.armwrite & (bus.armwaddr == 3'd3) & bus.armwdata[31] & prnotempty;
  assign pr_load = tt_iop & ((fn == 3'd4) | (fn == 3'd6));
  assign pr_xfer = prpend & (~prfull | pr_pop);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      enable  <= 1'b0;
      intenab <= 1'b0;
      kbovf   <= 1'b0;
      provf   <= 1'b0;
      prflag  <= 1'b0;
      prpend  <= 1'b0;
      kbwr    <= '0;
      kbrd    <= '0;
      prwr    <= '0;
      prrd    <= '0;
      kbcount <= '0;
      prcount <= '0;
      dev_q   <= '0;
      clr_q   <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      if (arm_w1) begin
        enable <= bus.armwdata[31];
        if (bus.armwdata[30]) kbovf <= 1'b0;
        if (bus.armwdata[29]) provf <= 1'b0;
      end
      if (kb_push_req & ~kb_push) kbovf <= 1'b1;

      if (kb_flush) begin
        kbrd    <= kbwr;
        kbcount <= '0;
      end else begin
        if (kb_push) kbwr <= kbwr + PTR_ONE;
        if (kb_pop)  kbrd <= kbrd + PTR_ONE;
        if (kb_push & ~kb_pop)      kbcount <= kbcount + CNT_ONE;
        else if (kb_pop & ~kb_push) kbcount <= kbcount - CNT_ONE;
      end

      if (pr_xfer) prwr <= prwr + PTR_ONE;
      if (pr_pop)  prrd <= prrd + PTR_ONE;
      if (pr_xfer & ~pr_pop)      prcount <= prcount + CNT_ONE;
      else if (pr_pop & ~pr_xfer) prcount <= prcount - CNT_ONE;

      // Bus outputs latch at iopstart and hold until iopstop releases them.
      if (bus.iopstop) begin
        dev_q  <= '0;
        clr_q  <= 1'b0;
        skip_q <= 1'b0;
      end
      if (kb_iop) begin
        case (fn)
          3'd1: skip_q  <= kbflag;
          3'd2: clr_q   <= 1'b1;
          3'd4: dev_q   <= {4'b0, kbhead};
          3'd5: intenab <= bus.cputodev[0];
          3'd6: begin
            clr_q <= 1'b1;
            dev_q <= kbflag ? {4'b0, kbhead} : 12'd0;
          end
          default: ;
        endcase
      end
      if (tt_iop) begin
        case (fn)
          3'd1:       skip_q <= prflag;
          3'd2, 3'd6: prflag <= 1'b0;
          3'd5:       skip_q <= int_rqst;
          default: ;
        endcase
      end

      // A char moving into the FIFO re-raises the flag; a fresh load always pends.
      if (pr_xfer) begin
        prpend <= 1'b0;
        prflag <= 1'b1;
      end
      if (pr_load) begin
        prpend <= 1'b1;
        if (prpend) provf <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK) begin
    if (kb_push) kbmem[kbwr] <= bus.armwdata[7:0];
    if (pr_xfer) prmem[prwr] <= prstage;
    if (pr_load) prstage     <= bus.cputodev[7:0];
  end

  always_comb begin
    rdata = '0;
    case (bus.armraddr)
      3'd0:    rdata = 32'h5454_2002;
      3'd1:    rdata = {enable, intenab, kbovf, provf, prflag, prpend, 26'b0};
      3'd2:    rdata = {kbfull, kbflag, 20'b0, 10'(kbcount)};
      3'd3:    rdata = {prnotempty, prfull, 10'b0, 10'(prcount), 2'b0, prhead};
      3'd4:    rdata = {26'b0, KBDEV};
      default: rdata = '0;
    endcase
  end

  assign bus.armrdata = rdata;
  assign bus.devtocpu = dev_q;
  assign bus.AC_CLEAR = clr_q;
  assign bus.IO_SKIP  = skip_q;
  assign bus.INT_RQST = int_rqst;

  logic unused_ok;
  assign unused_ok = ^{bus.armwdata[27:8], bus.cputodev[11:8]};
endmodule

// File: tb/tb_pdp8l_fifo_tty.sv
// Directed bench for pdp8l_fifo_tty: a vector table for single-cycle behaviour
// plus hand-written sequences for FIFO fill/overflow, printer staging and reset.
module tb_pdp8l_fifo_tty;
  logic CLOCK = 1'b0;
  logic RESET = 1'b0;
  int   tests = 0;
  int   fails = 0;

  pdp8l_fifo_tty_if bus();

  pdp8l_fifo_tty #(.KBDEV(6'o03), .DEPTHLOG2(4)) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct {
    string       name;
    logic        aw;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic        is;
    logic [11:0] op;
    logic [11:0] ac;
    logic        st;
    logic [2:0]  ra;
    logic [31:0] erd;
    logic [11:0] edev;
    logic        eclr;
    logic        eskip;
    logic        eint;
  } vec_t;

  vec_t vq[$];

  task automatic add(input string n, input logic aw, input logic [2:0] wa, input logic [31:0] wd,
                     input logic is, input logic [11:0] op, input logic [11:0] ac, input logic st,
                     input logic [2:0] ra, input logic [31:0] erd, input logic [11:0] edev,
                     input logic eclr, input logic eskip, input logic eint);
    vq.push_back('{n, aw, wa, wd, is, op, ac, st, ra, erd, edev, eclr, eskip, eint});
  endtask

  task automatic idle(input string n, input logic [2:0] ra, input logic [31:0] erd);
    add(n, 0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 0, ra, erd, 12'd0, 0, 0, 0);
  endtask

  task automatic wr(input string n, input logic [2:0] wa, input logic [31:0] wd,
                    input logic [2:0] ra, input logic [31:0] erd);
    add(n, 1, wa, wd, 0, 12'd0, 12'd0, 0, ra, erd, 12'd0, 0, 0, 0);
  endtask

  task automatic iop(input string n, input logic [11:0] op, input logic [11:0] ac,
                     input logic [2:0] ra, input logic [31:0] erd, input logic [11:0] edev,
                     input logic eclr, input logic eskip);
    add(n, 0, 3'd0, 32'd0, 1, op, ac, 0, ra, erd, edev, eclr, eskip, 0);
  endtask

  task automatic stp(input string n, input logic [2:0] ra, input logic [31:0] erd);
    add(n, 0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 1, ra, erd, 12'd0, 0, 0, 0);
  endtask

  task automatic cyc(input logic aw, input logic [2:0] wa, input logic [31:0] wd,
                     input logic is, input logic [11:0] op, input logic [11:0] ac, input logic st);
    @(negedge CLOCK);
    bus.armwrite = aw;
    bus.armwaddr = wa;
    bus.armwdata = wd;
    bus.iopstart = is;
    bus.ioopcode = op;
    bus.cputodev = ac;
    bus.iopstop  = st;
    @(posedge CLOCK);
    #1;
    bus.armwrite = 1'b0;
    bus.iopstart = 1'b0;
    bus.iopstop  = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    bus.armraddr = a;
    #1;
    d = bus.armrdata;
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", n, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  exp_heads [17];

    bus.armwrite = 0; bus.armraddr = 0; bus.armwaddr = 0; bus.armwdata = 0;
    bus.iopstart = 0; bus.iopstop = 0; bus.ioopcode = 0; bus.cputodev = 0;

    // Reset and identity registers
    idle("rst_id",   3'd0, 32'h5454_2002);
    idle("rst_ctl",  3'd1, 32'h0);
    idle("rst_kb",   3'd2, 32'h0);
    idle("rst_dev",  3'd4, 32'h0000_0003);
    iop ("iop_disabled", 12'o6035, 12'd1, 3'd1, 32'h0, 12'd0, 0, 0);
    wr  ("enable",   3'd1, 32'h8000_0000, 3'd1, 32'h8000_0000);
    // Keyboard path
    wr  ("push41",   3'd2, 32'h41, 3'd2, 32'h4000_0001);
    wr  ("push42",   3'd2, 32'h42, 3'd2, 32'h4000_0002);
    wr  ("push43",   3'd2, 32'h43, 3'd2, 32'h4000_0003);
    iop ("kb_skip",  12'o6031, 12'd0, 3'd2, 32'h4000_0003, 12'h000, 0, 1);
    stp ("stop1",    3'd2, 32'h4000_0003);
    iop ("kb_krb",   12'o6036, 12'd0, 3'd2, 32'h4000_0002, 12'h041, 1, 0);
    stp ("stop2",    3'd2, 32'h4000_0002);
    iop ("kb_kcc",   12'o6032, 12'd0, 3'd2, 32'h4000_0001, 12'h000, 1, 0);
    stp ("stop3",    3'd2, 32'h4000_0001);
    iop ("kb_krs",   12'o6034, 12'd0, 3'd2, 32'h4000_0001, 12'h043, 0, 0);
    stp ("stop4",    3'd2, 32'h4000_0001);
    iop ("kb_krb2",  12'o6036, 12'd0, 3'd2, 32'h0, 12'h043, 1, 0);
    stp ("stop5",    3'd2, 32'h0);
    iop ("kb_krb_empty", 12'o6036, 12'd0, 3'd2, 32'h0, 12'h000, 1, 0);
    stp ("stop6",    3'd2, 32'h0);
    // Printer path
    iop ("pr_tls",   12'o6046, 12'o110, 3'd1, 32'h8400_0000, 12'h000, 0, 0);
    stp ("pr_xfer",  3'd3, 32'h8000_0448);
    idle("pr_flag",  3'd1, 32'h8800_0000);
    iop ("pr_skip",  12'o6041, 12'd0, 3'd1, 32'h8800_0000, 12'h000, 0, 1);
    stp ("stop7",    3'd1, 32'h8800_0000);
    iop ("pr_tcf",   12'o6042, 12'd0, 3'd1, 32'h8000_0000, 12'h000, 0, 0);
    stp ("stop8",    3'd1, 32'h8000_0000);
    iop ("pr_noskip", 12'o6041, 12'd0, 3'd1, 32'h8000_0000, 12'h000, 0, 0);
    stp ("stop9",    3'd1, 32'h8000_0000);
    wr  ("pr_pop",   3'd3, 32'h8000_0000, 3'd1, 32'h8000_0000);
    // Simultaneous ARM push and IOP pop
    wr  ("push31",   3'd2, 32'h31, 3'd2, 32'h4000_0001);
    add ("push_pop", 1, 3'd2, 32'h32, 1, 12'o6036, 12'd0, 0, 3'd2, 32'h4000_0001, 12'h031, 1, 0, 0);
    stp ("stop10",   3'd2, 32'h4000_0001);
    iop ("head32",   12'o6034, 12'd0, 3'd2, 32'h4000_0001, 12'h032, 0, 0);
    stp ("stop11",   3'd2, 32'h4000_0001);
    iop ("pop32",    12'o6032, 12'd0, 3'd2, 32'h0, 12'h000, 1, 0);
    stp ("stop12",   3'd2, 32'h0);

    #2 RESET = 1'b1;
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK) RESET = 1'b0;

    foreach (vq[i]) begin
      cyc(vq[i].aw, vq[i].wa, vq[i].wd, vq[i].is, vq[i].op, vq[i].ac, vq[i].st);
      bus.armraddr = vq[i].ra;
      #1;
      chk(vq[i].name,
          64'({bus.armrdata, bus.devtocpu, bus.AC_CLEAR, bus.IO_SKIP, bus.INT_RQST}),
          64'({vq[i].erd, vq[i].edev, vq[i].eclr, vq[i].eskip, vq[i].eint}));
    end

    // Keyboard overflow: 17 pushes into 16 slots
    for (int i = 0; i < 17; i++) begin
      cyc(1, 3'd2, 32'(8'h61 + i), 0, 12'd0, 12'd0, 0);
      if (i == 15) begin
        rd(3'd2, d); chk("kb_full16", 64'(d), 64'hC000_0010);
      end
    end
    rd(3'd2, d); chk("kb_full17", 64'(d), 64'hC000_0010);
    rd(3'd1, d); chk("kb_ovf_set", 64'(d), 64'hA000_0000);
    cyc(1, 3'd1, 32'hC000_0000, 0, 12'd0, 12'd0, 0);
    rd(3'd1, d); chk("kb_ovf_clr", 64'(d), 64'h8000_0000);
    cyc(0, 3'd0, 32'd0, 1, 12'o6036, 12'd0, 0);
    chk("kb_order", 64'(bus.devtocpu), 64'h061);
    cyc(0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 1);
    cyc(1, 3'd1, 32'h9000_0000, 0, 12'd0, 12'd0, 0);
    rd(3'd2, d); chk("kb_flush", 64'(d), 64'h0);

    // Printer FIFO full, staging held until an ARM pop
    for (int i = 0; i < 16; i++) begin
      cyc(0, 3'd0, 32'd0, 1, 12'o6046, 12'(8'h60 + i), 0);
      cyc(0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 1);
    end
    rd(3'd3, d); chk("pr_full", 64'(d), 64'hC000_4060);
    cyc(0, 3'd0, 32'd0, 1, 12'o6046, 12'h05A, 0);
    rd(3'd1, d); chk("pr_pend", 64'(d), 64'h8400_0000);
    cyc(0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 1);
    rd(3'd1, d); chk("pr_pend_hold", 64'(d), 64'h8400_0000);
    cyc(1, 3'd3, 32'h8000_0000, 0, 12'd0, 12'd0, 0);
    rd(3'd1, d); chk("pr_pop_xfer", 64'(d), 64'h8800_0000);
    rd(3'd3, d); chk("pr_pop_cnt", 64'(d), 64'hC000_4061);
    cyc(0, 3'd0, 32'd0, 1, 12'o6046, 12'h05B, 0);
    cyc(0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 1);
    cyc(0, 3'd0, 32'd0, 1, 12'o6046, 12'h05C, 0);
    rd(3'd1, d); chk("pr_provf", 64'(d), 64'h9400_0000);
    cyc(0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 1);
    for (int i = 0; i < 15; i++) exp_heads[i] = 8'h61 + 8'(i);
    exp_heads[15] = 8'h5A;
    exp_heads[16] = 8'h5C;
    for (int i = 0; i < 17; i++) begin
      rd(3'd3, d); chk($sformatf("pr_head%0d", i), 64'(d[7:0]), 64'(exp_heads[i]));
      cyc(1, 3'd3, 32'h8000_0000, 0, 12'd0, 12'd0, 0);
    end
    rd(3'd3, d); chk("pr_drained", 64'(d & 32'hC00F_FC00), 64'h0);
    cyc(1, 3'd1, 32'hA000_0000, 0, 12'd0, 12'd0, 0);
    rd(3'd1, d); chk("pr_provf_clr", 64'(d), 64'h8800_0000);

    // Interrupt request, then asynchronous reset in the middle of an IOP
    cyc(1, 3'd2, 32'h37, 0, 12'd0, 12'd0, 0);
    cyc(0, 3'd0, 32'd0, 1, 12'o6035, 12'd1, 0);
    chk("int_rqst", 64'(bus.INT_RQST), 64'h1);
    cyc(0, 3'd0, 32'd0, 0, 12'd0, 12'd0, 1);
    cyc(0, 3'd0, 32'd0, 1, 12'o6045, 12'd0, 0);
    chk("tsk_skip", 64'(bus.IO_SKIP), 64'h1);
    #1 RESET = 1'b1;
    #1;
    chk("rst_async", 64'({bus.INT_RQST, bus.IO_SKIP, bus.AC_CLEAR, bus.devtocpu}), 64'h0);
    rd(3'd2, d); chk("rst_kbcnt", 64'(d), 64'h0);
    rd(3'd3, d); chk("rst_prcnt", 64'(d & 32'hC00F_FC00), 64'h0);
    @(negedge CLOCK) RESET = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
